pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Consumer end of the PLL refclk/rst/locked interface.
- Runs on the 50 MHz reference clock, so it operates while the PLL is unlocked.
- Drives the PLL reset and qualifies `locked`, then releases the downstream system reset and ready flag for the SDRAM controller and test logic.
- Retries lock with a timeout, detects lock loss in operation, and reports unrecoverable failure.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per attempt.
- LOCK_TIMEOUT, 50000: cycles allowed from pll_rst release to qualified lock (1 ms).
- STABLE_CYCLES, 5000: consecutive synchronized-locked samples required before release (100 us).
- MAX_RETRIES, 3: retries after the first attempt before FAIL.
- LOSS_W, 8: width of the lock-loss counter.

Ports:
- refclk  in  1  reference clock; sole clock.
- rst_n  in  1  synchronous reset, active-low.
- locked  in  1  PLL locked, asynchronous to refclk.
- relock_req  in  1  single-cycle request to restart sequence.
- pll_rst  out  1  PLL reset, active-high.
- sys_rst_n  out  1  downstream reset, active-low.
- ready  out  1  clocks valid; equals ~sys_rst_n.
- fail  out  1  retries exhausted.
- retry_count  out  $clog2(MAX_RETRIES+1)  timeouts in current sequence.
- lock_loss_count  out  LOSS_W  saturating count of lock losses in RUN.

Behaviour:
- Reset: one clock (refclk); reset is synchronous and active-low (rst_n). While rst_n is sampled low: pll_rst=1, sys_rst_n=0, ready=0, fail=0, retry_count=0, lock_loss_count=0, state=RESET_PLL, all counters 0. Applies from any state, including mid-sequence.
- All outputs are registered.
- locked passes through a 2-FF synchronizer to give locked_s, which is all the FSM sees.
- RESET_PLL:
  - pll_rst=1, sys_rst_n=0.
  - Counts PLL_RST_CYCLES edges, then goes to WAIT_LOCK. pll_rst=0 on that same edge.
  - Clears the timeout counter.
- WAIT_LOCK:
  - locked_s=1 → STABLE, stable counter=1.
  - Timeout counter increments every cycle in WAIT_LOCK and STABLE.
- STABLE:
  - locked_s=1 increments the stable counter.
  - Counter reaching STABLE_CYCLES → RUN; sys_rst_n=1 and ready=1 on that edge.
  - locked_s=0 → WAIT_LOCK, stable counter cleared, timeout counter not cleared.
- Timeout (counter == LOCK_TIMEOUT in WAIT_LOCK or STABLE):
  - If retry_count < MAX_RETRIES: retry_count++, → RESET_PLL.
  - Else → FAIL.
  - Timeout and stable-complete on the same edge: stable-complete wins.
- RUN:
  - locked_s=0 → RESET_PLL; sys_rst_n=0 and pll_rst=1 on that edge. lock_loss_count++ (saturating at all-ones); retry_count=0.
  - relock_req=1 → same, without incrementing lock_loss_count.
  - Both in the same cycle → treated as a loss (counter increments).
- FAIL:
  - pll_rst=1, sys_rst_n=0, fail=1.
  - relock_req → RESET_PLL with fail=0 and retry_count=0.
- relock_req is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- Latency, normal path: STABLE_CYCLES+2 edges from the first edge sampling locked=1 to the edge where sys_rst_n rises.
- Lock loss: 2 edges from the first edge sampling locked=0 to sys_rst_n falling.
- Total attempts before FAIL = MAX_RETRIES+1.

Decomposition:
- Package pll_rst_pkg holds:
  - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL};
  - default timing constants;
  - counter-width function based on $clog2.
- Sub-module bit_sync_2ff (parameterized reset value 0) synchronizes locked. It is reusable for other async status inputs.

Test Plan:
All tests use PLL_RST_CYCLES=4, LOCK_TIMEOUT=40, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Normal: rst_n high; locked rises 10 cycles after pll_rst falls → pll_rst high exactly 4 edges after reset; sys_rst_n and ready rise exactly 10 edges after locked is first sampled high; retry_count=0.
2. Glitch: locked low for 1 cycle at stable count 5 → stable restarts; release occurs 10 edges after locked returns; no retry.
3. Timeout: locked held 0 → three pll_rst pulses of 4 cycles each, 40 cycles apart; retry_count goes 1, 2; after the third timeout fail=1 and pll_rst stays high.
4. Loss in RUN: locked drops → sys_rst_n=0 2 edges later; lock_loss_count=1; 4-cycle pll_rst pulse; relock releases again. With 256 losses the counter saturates at 255.
5. relock_req in FAIL → fail=0, retry_count=0, sequence restarts. relock_req in RUN → restart with lock_loss_count unchanged. relock_req in WAIT_LOCK → ignored.
6. rst_n low mid-STABLE for 1 cycle → all outputs at reset values on the next edge; full sequence restarts.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types, default timing and counter sizing for the PLL reset sequencer.
// Default timings assume the 50 MHz reference clock.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } pll_state_e;

    localparam int unsigned DefPllRstCycles = 16;
    localparam int unsigned DefLockTimeout  = 50000;
    localparam int unsigned DefStableCycles = 5000;
    localparam int unsigned DefMaxRetries   = 3;
    localparam int unsigned DefLossW        = 8;

    // Bits needed to hold every value from 0 to max_val inclusive.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL lock/reset status bundle between the reset sequencer (master)
// and the PLL plus downstream consumers (slave).
interface pll_reset_sequencer_if #(
    parameter int unsigned RETRY_W = 2,
    parameter int unsigned LOSS_W  = 8
);
    logic               locked;
    logic               relock_req;
    logic               pll_rst;
    logic               sys_rst_n;
    logic               ready;
    logic               fail;
    logic [RETRY_W-1:0] retry_count;
    logic [LOSS_W-1:0]  lock_loss_count;

    modport master (
        input  locked, relock_req,
        output pll_rst, sys_rst_n, ready, fail, retry_count, lock_loss_count
    );

    modport slave (
        output locked, relock_req,
        input  pll_rst, sys_rst_n, ready, fail, retry_count, lock_loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer_bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Reset is synchronous; ResetVal is what q_o shows while held in reset.
module bit_sync_2ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock with retry/timeout, and releases the
// downstream reset once lock has been stable long enough.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
    parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
    parameter int unsigned STABLE_CYCLES  = DefStableCycles,
    parameter int unsigned MAX_RETRIES    = DefMaxRetries,
    parameter int unsigned LOSS_W         = DefLossW
) (
    input logic                   refclk,
    input logic                   rst_n,
    pll_reset_sequencer_if.master bus
);
    localparam int unsigned RstW    = cnt_w(PLL_RST_CYCLES);
    localparam int unsigned TmoW    = cnt_w(LOCK_TIMEOUT);
    localparam int unsigned StableW = cnt_w(STABLE_CYCLES);
    localparam int unsigned RetryW  = cnt_w(MAX_RETRIES);

    localparam logic [RstW-1:0]    RstLast     = RstW'(PLL_RST_CYCLES - 1);
    localparam logic [TmoW-1:0]    TmoLimit    = TmoW'(LOCK_TIMEOUT);
    localparam logic [StableW-1:0] StableLimit = StableW'(STABLE_CYCLES);
    localparam logic [RetryW-1:0]  RetryMax    = RetryW'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LossMax     = '1;

    pll_state_e         state_q, state_d;
    logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [TmoW-1:0]    tmo_q, tmo_d, tmo_inc;
    logic [StableW-1:0] stable_q, stable_d;
    logic [RetryW-1:0]  retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               pll_rst_q, sys_rst_n_q, fail_q;
    logic               locked_s;
    logic               timeout;

    bit_sync_2ff #(
        .ResetVal (1'b0)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (bus.locked),
        .q_o    (locked_s)
    );

    assign tmo_inc = tmo_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        tmo_d     = tmo_q;
        stable_d  = stable_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        timeout   = 1'b0;

        unique case (state_q)
            StResetPll: begin
                tmo_d    = '0;
                stable_d = '0;
                if (rst_cnt_q == RstLast) begin
                    state_d   = StWaitLock;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                tmo_d = tmo_inc;
                if (tmo_inc == TmoLimit) begin
                    timeout = 1'b1;
                end else if (locked_s) begin
                    state_d  = StStable;
                    stable_d = StableW'(1);
                end
            end
            StStable: begin
                tmo_d = tmo_inc;
                // Completing the stable window takes priority over a coincident timeout.
                if (locked_s && stable_q == StableLimit) begin
                    state_d = StRun;
                end else if (tmo_inc == TmoLimit) begin
                    timeout = 1'b1;
                end else if (locked_s) begin
                    stable_d = stable_q + 1'b1;
                end else begin
                    state_d  = StWaitLock;
                    stable_d = '0;
                end
            end
            StRun: begin
                if (!locked_s || bus.relock_req) begin
                    state_d = StResetPll;
                    retry_d = '0;
                    if (!locked_s && loss_q != LossMax) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            StFail: begin
                if (bus.relock_req) begin
                    state_d = StResetPll;
                    retry_d = '0;
                end
            end
            default: state_d = StResetPll;
        endcase

        if (timeout) begin
            if (retry_q < RetryMax) begin
                retry_d = retry_q + 1'b1;
                state_d = StResetPll;
            end else begin
                state_d = StFail;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= StResetPll;
            rst_cnt_q   <= '0;
            tmo_q       <= '0;
            stable_q    <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_q       <= tmo_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            // Outputs are decoded from the next state so they change on the transition edge.
            pll_rst_q   <= (state_d == StResetPll) || (state_d == StFail);
            sys_rst_n_q <= (state_d == StRun);
            fail_q      <= (state_d == StFail);
        end
    end

    assign bus.pll_rst         = pll_rst_q;
    assign bus.sys_rst_n       = sys_rst_n_q;
    assign bus.ready           = sys_rst_n_q;
    assign bus.fail            = fail_q;
    assign bus.retry_count     = retry_q;
    assign bus.lock_loss_count = loss_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_pll_reset_sequencer;
    localparam int T_PLL   = 4;
    localparam int T_TO    = 40;
    localparam int T_ST    = 8;
    localparam int T_RETRY = 2;

    localparam int PRst  = 0;
    localparam int PWait = 1;
    localparam int PStab = 2;
    localparam int PRun  = 3;
    localparam int PFail = 4;

    logic refclk = 1'b0;
    logic rst_n = 1'b0;
    logic locked = 1'b0;
    logic relock_req = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    pll_reset_sequencer_if #(.RETRY_W(2), .LOSS_W(8)) bus ();

    assign bus.locked     = locked;
    assign bus.relock_req = relock_req;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (T_PLL),
        .LOCK_TIMEOUT   (T_TO),
        .STABLE_CYCLES  (T_ST),
        .MAX_RETRIES    (T_RETRY),
        .LOSS_W         (8)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    // Behavioural model: phase plus countdown/elapsed time, sync as a 2-deep history.
    int         m_phase = PRst;
    int         m_left = T_PLL;
    int         m_elapsed = 0;
    int         m_good = 0;
    int         m_retry = 0;
    int         m_loss = 0;
    logic [1:0] m_sync = 2'b00;
    bit         m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic enter_reset();
        m_phase = PRst;
        m_left  = T_PLL;
    endtask

    task automatic lock_timeout();
        if (m_retry < T_RETRY) begin
            m_retry++;
            enter_reset();
        end else begin
            m_phase = PFail;
        end
    endtask

    task automatic model_step();
        logic ls;
        ls = m_sync[1];
        if (!rst_n) begin
            m_valid   = 1'b1;
            enter_reset();
            m_elapsed = 0;
            m_good    = 0;
            m_retry   = 0;
            m_loss    = 0;
            m_sync    = 2'b00;
            return;
        end
        m_sync = {m_sync[0], locked};
        case (m_phase)
            PRst: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase   = PWait;
                    m_elapsed = 0;
                end
            end
            PWait: begin
                m_elapsed++;
                if (m_elapsed == T_TO) lock_timeout();
                else if (ls) begin
                    m_phase = PStab;
                    m_good  = 1;
                end
            end
            PStab: begin
                m_elapsed++;
                if (ls && m_good == T_ST) m_phase = PRun;
                else if (m_elapsed == T_TO) lock_timeout();
                else if (ls) m_good++;
                else begin
                    m_phase = PWait;
                    m_good  = 0;
                end
            end
            PRun: begin
                if (!ls || relock_req) begin
                    if (!ls) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                    m_retry = 0;
                    enter_reset();
                end
            end
            PFail: begin
                if (relock_req) begin
                    m_retry = 0;
                    enter_reset();
                end
            end
            default: ;
        endcase
    endtask

    always @(negedge refclk) begin
        if (m_valid) begin
            check("pll_rst", 32'(bus.pll_rst), 32'(m_phase == PRst || m_phase == PFail));
            check("sys_rst_n", 32'(bus.sys_rst_n), 32'(m_phase == PRun));
            check("ready", 32'(bus.ready), 32'(m_phase == PRun));
            check("fail", 32'(bus.fail), 32'(m_phase == PFail));
            check("retry_count", 32'(bus.retry_count), 32'(m_retry));
            check("lock_loss_count", 32'(bus.lock_loss_count), 32'(m_loss));
        end
    end

    task automatic step();
        @(posedge refclk);
        #1;
        model_step();
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.pll_rst;
            1:       return bus.sys_rst_n;
            default: return bus.fail;
        endcase
    endfunction

    // Steps until the selected output equals val; n is the number of edges taken.
    task automatic wait_sig(input int which, input logic val, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sig(which) !== val && n < max);
        if (sig(which) !== val) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_sig%0d: got %b expected %b within %0d edges", which, sig(which),
                     val, max);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"}, 32'(bus.pll_rst), 32'd1);
        check({tag, "_sys_rst_n"}, 32'(bus.sys_rst_n), 32'd0);
        check({tag, "_ready"}, 32'(bus.ready), 32'd0);
        check({tag, "_fail"}, 32'(bus.fail), 32'd0);
        check({tag, "_retry"}, 32'(bus.retry_count), 32'd0);
        check({tag, "_loss"}, 32'(bus.lock_loss_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tog;

        // Reset and normal lock.
        rst_n = 1'b0;
        step();
        check_reset_values("rst");
        rst_n = 1'b1;
        wait_sig(0, 1'b0, 20, n);
        check("t1_pll_rst_width", 32'(n), 32'd4);
        repeat (9) step();
        locked = 1'b1;
        step();
        wait_sig(1, 1'b1, 30, n);
        check("t1_release_latency", 32'(n), 32'd10);
        check("t1_ready", 32'(bus.ready), 32'd1);
        check("t1_retry", 32'(bus.retry_count), 32'd0);

        // Lock loss in RUN.
        locked = 1'b0;
        step();
        wait_sig(1, 1'b0, 10, n);
        check("t4_loss_latency", 32'(n), 32'd2);
        check("t4_loss_count", 32'(bus.lock_loss_count), 32'd1);
        check("t4_pll_rst", 32'(bus.pll_rst), 32'd1);
        wait_sig(0, 1'b0, 20, n);
        check("t4_pll_rst_width", 32'(n), 32'd4);

        // Glitch during the stable window restarts it.
        locked = 1'b1;
        step();
        repeat (4) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        step();
        wait_sig(1, 1'b1, 30, n);
        check("t2_release_after_glitch", 32'(n), 32'd10);
        check("t2_retry", 32'(bus.retry_count), 32'd0);

        // relock_req in RUN keeps the loss count.
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("t5_run_relock_sys", 32'(bus.sys_rst_n), 32'd0);
        check("t5_run_relock_pll", 32'(bus.pll_rst), 32'd1);
        check("t5_run_relock_loss", 32'(bus.lock_loss_count), 32'd1);
        wait_sig(1, 1'b1, 40, n);
        check("t5_relock_to_run", 32'(n), 32'd13);

        // relock_req in WAIT_LOCK is ignored; then run into timeouts.
        locked = 1'b0;
        step();
        wait_sig(1, 1'b0, 10, n);
        wait_sig(0, 1'b0, 20, n);
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("t5_wait_relock_ignored", 32'(bus.pll_rst), 32'd0);
        wait_sig(0, 1'b1, 60, n);
        check("t3_first_timeout", 32'(n), 32'd39);
        check("t3_retry1", 32'(bus.retry_count), 32'd1);
        wait_sig(0, 1'b0, 20, n);
        check("t3_pulse2_width", 32'(n), 32'd4);
        wait_sig(0, 1'b1, 60, n);
        check("t3_second_timeout", 32'(n), 32'd40);
        check("t3_retry2", 32'(bus.retry_count), 32'd2);
        wait_sig(0, 1'b0, 20, n);
        check("t3_pulse3_width", 32'(n), 32'd4);
        wait_sig(0, 1'b1, 60, n);
        check("t3_third_timeout", 32'(n), 32'd40);
        check("t3_fail", 32'(bus.fail), 32'd1);
        check("t3_fail_retry", 32'(bus.retry_count), 32'd2);
        repeat (10) step();
        check("t3_fail_pll_held", 32'(bus.pll_rst), 32'd1);
        check("t3_fail_held", 32'(bus.fail), 32'd1);

        // relock_req in FAIL restarts.
        locked = 1'b1;
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("t5_fail_relock_fail", 32'(bus.fail), 32'd0);
        check("t5_fail_relock_retry", 32'(bus.retry_count), 32'd0);
        check("t5_fail_relock_pll", 32'(bus.pll_rst), 32'd1);
        wait_sig(0, 1'b0, 20, n);
        check("t5_fail_relock_width", 32'(n), 32'd4);

        // Reset mid-STABLE.
        repeat (6) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_values("t6");
        wait_sig(0, 1'b0, 20, n);
        check("t6_pll_rst_width", 32'(n), 32'd4);
        wait_sig(1, 1'b1, 30, n);
        check("t6_release", 32'(n), 32'd9);

        // 256 lock losses saturate the counter.
        for (int i = 0; i < 256; i++) begin
            locked = 1'b0;
            step();
            locked = 1'b1;
            wait_sig(1, 1'b0, 10, n);
            wait_sig(1, 1'b1, 40, n);
            if (i == 254) check("t4_loss_255", 32'(bus.lock_loss_count), 32'd255);
        end
        check("t4_loss_saturated", 32'(bus.lock_loss_count), 32'd255);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 6; blk++) begin
            case ($urandom_range(2))
                0:       tog = 4;
                1:       tog = 30;
                default: tog = 200;
            endcase
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(tog - 1) == 0) locked = ~locked;
                relock_req = ($urandom_range(40) == 0);
                rst_n = ($urandom_range(400) != 0);
                step();
            end
        end
        relock_req = 1'b0;
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
